// File: rtl/modbus_rtu_tx.sv
// MODBUS RTU frame transmitter: serialises payload bytes as 11-bit UART characters,
// appends CRC-16/MODBUS (low byte first) and holds the inter-frame silence.
module modbus_rtu_tx #(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned BAUD_RATE    = 9600,
  parameter bit          PARITY_EN    = 1'b1,
  parameter int unsigned SILENCE_BITS = 39
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       uart_tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned BAUD_DIV   = CLK_FREQ / BAUD_RATE;
  localparam int unsigned GAP_CYCLES = SILENCE_BITS * BAUD_DIV;
  localparam int unsigned BW         = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned GW         = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PAYLOAD,
    S_CRC_LO,
    S_CRC_HI,
    S_GAP
  } state_t;

  state_t          state, state_nx;
  logic [15:0]     crc;
  logic            last_seen;
  logic            char_active;
  logic [3:0]      bit_idx;
  logic [BW-1:0]   baud_cnt;
  logic [9:0]      shreg;
  logic [GW-1:0]   gap_cnt;

  logic            bit_end, char_end, gap_end;
  logic            ready_c, accept, load;
  logic [7:0]      load_byte;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic ninth_bit(input logic [7:0] b);
    return PARITY_EN ? ^b : 1'b1;
  endfunction

  assign bit_end  = char_active && (baud_cnt == BW'(BAUD_DIV - 1));
  assign char_end = bit_end && (bit_idx == 4'd10);
  assign gap_end  = (state == S_GAP) && (gap_cnt == GW'(GAP_CYCLES - 1));
  assign accept   = tx_valid && ready_c;
  assign tx_ready = ready_c && !rst;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Frame sequencing; the last stop-bit cycle doubles as the load slot for the next character.
  always_comb begin
    state_nx  = state;
    ready_c   = 1'b0;
    load      = 1'b0;
    load_byte = tx_data;
    case (state)
      S_IDLE: begin
        ready_c = 1'b1;
        if (tx_valid) begin
          load     = 1'b1;
          state_nx = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        ready_c = !last_seen && (!char_active || char_end);
        if (ready_c && tx_valid) begin
          load = 1'b1;
        end else if (last_seen && char_end) begin
          load      = 1'b1;
          load_byte = crc[7:0];
          state_nx  = S_CRC_LO;
        end
      end
      S_CRC_LO: begin
        if (char_end) begin
          load      = 1'b1;
          load_byte = crc[15:8];
          state_nx  = S_CRC_HI;
        end
      end
      S_CRC_HI: begin
        if (char_end) state_nx = S_GAP;
      end
      S_GAP: begin
        if (gap_end) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Character engine, CRC accumulator and frame status.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc         <= 16'hFFFF;
      last_seen   <= 1'b0;
      char_active <= 1'b0;
      bit_idx     <= 4'd0;
      baud_cnt    <= '0;
      shreg       <= '1;
      gap_cnt     <= '0;
      uart_tx     <= 1'b1;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= (state == S_GAP) && (gap_cnt == GW'(GAP_CYCLES - 2));
      gap_cnt    <= (state == S_GAP) ? gap_cnt + GW'(1) : '0;

      if (accept) begin
        crc       <= crc_byte(crc, tx_data);
        last_seen <= tx_last;
        busy      <= 1'b1;
      end
      if (gap_end) begin
        crc       <= 16'hFFFF;
        last_seen <= 1'b0;
        busy      <= 1'b0;
      end

      if (load) begin
        char_active <= 1'b1;
        bit_idx     <= 4'd0;
        baud_cnt    <= '0;
        uart_tx     <= 1'b0;
        shreg       <= {1'b1, ninth_bit(load_byte), load_byte};
      end else if (char_end) begin
        char_active <= 1'b0;
        bit_idx     <= 4'd0;
        baud_cnt    <= '0;
        uart_tx     <= 1'b1;
      end else if (bit_end) begin
        baud_cnt <= '0;
        bit_idx  <= bit_idx + 4'd1;
        uart_tx  <= shreg[0];
        shreg    <= {1'b1, shreg[9:1]};
      end else if (char_active) begin
        baud_cnt <= baud_cnt + BW'(1);
      end
    end
  end

endmodule

// File: tb/tb_modbus_rtu_tx.sv
// Bench for modbus_rtu_tx: a waveform-level model predicts every output per cycle
// for a parity and a no-parity instance; a line decoder pins known frames.
module tb_modbus_rtu_tx;

  localparam int BD  = 16;
  localparam int GAP = 39 * BD;

  logic       clk, rst, tx_valid, tx_last;
  logic [7:0] tx_data;
  logic       tx_ready_p, uart_p, busy_p, done_p;
  logic       tx_ready_n, uart_n, busy_n, done_n;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 0;

  logic [9:0] rx_p[$];
  logic [9:0] rx_n[$];
  logic [7:0] ref_frame [8];

  // Model state: expected line levels keyed by cycle, plus frame bookkeeping.
  bit          exp_p[int];
  bit          exp_n[int];
  bit          m_in_frame = 0;
  bit          m_last     = 0;
  int          m_line_end = -1;
  int          m_done_cyc = 0;
  int          m_busy_from = 0;
  logic [15:0] m_crc = 16'hFFFF;

  modbus_rtu_tx #(.CLK_FREQ(160), .BAUD_RATE(10), .PARITY_EN(1'b1), .SILENCE_BITS(39)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_ready(tx_ready_p), .uart_tx(uart_p), .busy(busy_p), .frame_done(done_p));

  modbus_rtu_tx #(.CLK_FREQ(160), .BAUD_RATE(10), .PARITY_EN(1'b0), .SILENCE_BITS(39)) dut_np (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_ready(tx_ready_n), .uart_tx(uart_n), .busy(busy_n), .frame_done(done_n));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    repeat (8) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  task automatic sched_char(input int start, input logic [7:0] d);
    logic [10:0] ch;
    ch = {1'b1, ^d, d, 1'b0};
    for (int j = 0; j < 11; j++) begin
      for (int c = 0; c < BD; c++) begin
        exp_p[start + j*BD + c] = ch[j];
        exp_n[start + j*BD + c] = (j == 9) ? 1'b1 : ch[j];
      end
    end
  endtask

  // Per-cycle comparison against the model, then advance the model by this cycle's inputs.
  always @(negedge clk) begin
    if (chk_en) begin
      bit e_tp, e_tn, e_ready, e_busy, e_done;
      e_tp    = exp_p.exists(cyc) ? exp_p[cyc] : 1'b1;
      e_tn    = exp_n.exists(cyc) ? exp_n[cyc] : 1'b1;
      e_ready = rst ? 1'b0 : (!m_in_frame ? 1'b1 : (m_last ? 1'b0 : (cyc >= m_line_end)));
      e_busy  = m_in_frame && (cyc >= m_busy_from);
      e_done  = m_in_frame && (cyc == m_done_cyc);
      chk("uart_tx_p", 32'(uart_p), 32'(e_tp));
      chk("uart_tx_n", 32'(uart_n), 32'(e_tn));
      chk("tx_ready_p", 32'(tx_ready_p), 32'(e_ready));
      chk("tx_ready_n", 32'(tx_ready_n), 32'(e_ready));
      chk("busy_p", 32'(busy_p), 32'(e_busy));
      chk("busy_n", 32'(busy_n), 32'(e_busy));
      chk("frame_done_p", 32'(done_p), 32'(e_done));
      chk("frame_done_n", 32'(done_n), 32'(e_done));
      if (exp_p.exists(cyc)) exp_p.delete(cyc);
      if (exp_n.exists(cyc)) exp_n.delete(cyc);
      if (rst) begin
        m_in_frame = 0; m_last = 0; m_crc = 16'hFFFF; m_line_end = -1;
        exp_p.delete(); exp_n.delete();
      end else if (e_done) begin
        m_in_frame = 0; m_last = 0; m_crc = 16'hFFFF;
      end else if (tx_valid && e_ready) begin
        if (!m_in_frame) begin
          m_in_frame  = 1;
          m_busy_from = cyc + 1;
        end
        sched_char(cyc + 1, tx_data);
        m_line_end = cyc + 11*BD;
        m_crc      = crc_upd(m_crc, tx_data);
        if (tx_last) begin
          m_last = 1;
          sched_char(m_line_end + 1, m_crc[7:0]);
          sched_char(m_line_end + 1 + 11*BD, m_crc[15:8]);
          m_line_end = m_line_end + 22*BD;
          m_done_cyc = m_line_end + GAP;
        end
      end
    end
  end

  // Mid-bit UART sampler; pushes {bit10, bit9, data}.
  task automatic rx_decode(input bit which);
    logic [10:1] b;
    forever begin
      @(negedge clk);
      if ((which ? uart_n : uart_p) === 1'b0) begin
        repeat (BD/2) @(negedge clk);
        for (int j = 1; j <= 10; j++) begin
          repeat (BD) @(negedge clk);
          b[j] = which ? uart_n : uart_p;
        end
        if (which) rx_n.push_back(b[10:1]);
        else       rx_p.push_back(b[10:1]);
      end
    end
  endtask

  initial rx_decode(1'b0);
  initial rx_decode(1'b1);

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] d, input bit last);
    int  n;
    bit  ok;
    n = 0; ok = 0;
    tx_data = d; tx_last = last; tx_valid = 1'b1;
    while (!ok && n < 20000) begin
      @(negedge clk);
      ok = (tx_ready_p === 1'b1);
      @(posedge clk); #1;
      n++;
    end
    if (!ok) chk("accept_timeout", 32'(n), 32'd0);
    tx_valid = 1'b0; tx_last = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_p !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    chk("frame_done_seen", 32'(done_p), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic send_ref(input int gap_at, input int gap_len);
    for (int i = 0; i < 6; i++) begin
      send_byte(ref_frame[i], i == 5);
      if (i == gap_at) idle(gap_len);
    end
  endtask

  task automatic check_ref(input string nm, input int off);
    chk({nm, "_count"}, 32'(rx_p.size()), 32'(off + 8));
    for (int i = 0; i < 8; i++) begin
      if (off + i < rx_p.size())
        chk(nm, 32'(rx_p[off + i]), 32'({1'b1, ^ref_frame[i], ref_frame[i]}));
    end
  endtask

  initial begin
    bit saw;
    int n;
    rst = 1'b1; tx_valid = 1'b0; tx_last = 1'b0; tx_data = 8'h00;
    ref_frame = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
    repeat (3) @(posedge clk); #1;
    chk_en = 1;
    @(negedge clk);
    chk("rst_tx_ready", 32'(tx_ready_p), 32'd0);
    chk("rst_uart_tx", 32'(uart_p), 32'd1);
    chk("rst_busy", 32'(busy_p), 32'd0);
    chk("rst_frame_done", 32'(done_p), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_tx_ready", 32'(tx_ready_p), 32'd1);
    @(posedge clk); #1;

    // Reference frame, back-to-back characters
    rx_p.delete(); rx_n.delete();
    send_ref(-1, 0);
    wait_done();
    check_ref("ref_frame", 0);

    // Single byte 0x55: even parity bit is 0
    rx_p.delete(); rx_n.delete();
    send_byte(8'h55, 1'b1);
    wait_done();
    chk("b55_p", 32'((rx_p.size() > 0) ? rx_p[0] : 10'h000), 32'h255);
    chk("b55_n", 32'((rx_n.size() > 0) ? rx_n[0] : 10'h000), 32'h355);

    // Byte 0x01: bit9 is 1 in both formats
    rx_p.delete(); rx_n.delete();
    send_byte(8'h01, 1'b1);
    wait_done();
    chk("b01_p", 32'((rx_p.size() > 0) ? rx_p[0] : 10'h000), 32'h301);
    chk("b01_n", 32'((rx_n.size() > 0) ? rx_n[0] : 10'h000), 32'h301);

    // Next frame presented during CRC and gap of the previous one
    rx_p.delete(); rx_n.delete();
    send_byte(8'hAB, 1'b0);
    send_byte(8'hCD, 1'b1);
    send_ref(-1, 0);
    wait_done();
    check_ref("held_frame", 4);

    // Upstream stall of 100 cycles between bytes 2 and 3
    rx_p.delete(); rx_n.delete();
    send_ref(1, 100);
    wait_done();
    check_ref("stall_frame", 0);

    // Reset in a data bit of byte 2
    send_byte(8'h01, 1'b0);
    send_byte(8'h03, 1'b0);
    idle(20);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_uart_tx", 32'(uart_p), 32'd1);
    chk("mid_rst_busy", 32'(busy_p), 32'd0);
    saw = 0;
    repeat (800) begin @(negedge clk); if (done_p === 1'b1) saw = 1; end
    chk("mid_rst_no_done", 32'(saw), 32'd0);
    @(posedge clk); #1;
    rx_p.delete(); rx_n.delete();
    send_ref(-1, 0);
    wait_done();
    check_ref("post_rst_frame", 0);

    // Random frames, gaps and held-valid starts
    for (int f = 0; f < 12; f++) begin
      n = int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) begin
        send_byte(8'($urandom), i == n - 1);
        if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(0, 20)));
      end
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 40)));
    end
    wait_done();
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
